// File: rtl/store_pkg.sv
// Shared types for the store path: size encodings and the buffered entry.
// Imported by store_lane_narrow and store_narrow_buffer.
package store_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } store_entry_t;

endpackage

// File: rtl/store_lane_narrow.sv
// Narrows a register value onto little-endian byte lanes, with byte enables.
// Ports: size_i, lane_i (addr[1:0]), data_i -> data_o, be_o, illegal_o.
module store_lane_narrow
  import store_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic [3:0]  be_o,
  output logic        illegal_o
);

  always_comb begin
    data_o    = '0;
    be_o      = '0;
    illegal_o = 1'b0;
    unique case (size_e'(size_i))
      SZ_BYTE: begin
        data_o = {4{data_i[7:0]}};
        be_o   = 4'b0001 << lane_i;
      end
      SZ_HALF: begin
        data_o    = {2{data_i[15:0]}};
        be_o      = lane_i[1] ? 4'b1100 : 4'b0011;
        illegal_o = lane_i[0];
      end
      SZ_WORD: begin
        data_o    = data_i;
        be_o      = 4'b1111;
        illegal_o = (lane_i != 2'b00);
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_narrow_buffer.sv
// Store buffer: narrows MEM-stage stores and drains them in order to dmem.
// Ports: req_* (valid/ready in), mem_* (valid/ready out), misalign_o, empty_o.
module store_narrow_buffer
  import store_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_size_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_data_i,
  output logic        mem_valid_o,
  input  logic        mem_ready_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic [3:0]  mem_be_o,
  output logic        misalign_o,
  output logic        empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  store_entry_t buf_q [DEPTH];
  store_entry_t wr_entry;
  store_entry_t head;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          misalign_q, misalign_d;

  logic [31:0] lane_data;
  logic [3:0]  lane_be;
  logic        illegal;
  logic        full;
  logic        hs;
  logic        push;
  logic        pop;

  store_lane_narrow u_narrow (
    .size_i    (req_size_i),
    .lane_i    (req_addr_i[1:0]),
    .data_i    (req_data_i),
    .data_o    (lane_data),
    .be_o      (lane_be),
    .illegal_o (illegal)
  );

  assign wr_entry.addr = {req_addr_i[31:2], 2'b00};
  assign wr_entry.data = lane_data;
  assign wr_entry.be   = lane_be;

  assign full    = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

  // Ready is a pure function of count: no path from mem_ready_i.
  assign req_ready_o = !full;
  assign hs          = req_valid_i && req_ready_o;
  assign push        = hs && !illegal;
  assign pop         = mem_valid_o && mem_ready_i;

  assign head        = buf_q[rd_ptr_q];
  assign mem_valid_o = !empty_o;
  assign mem_addr_o  = mem_valid_o ? head.addr : '0;
  assign mem_data_o  = mem_valid_o ? head.data : '0;
  assign mem_be_o    = mem_valid_o ? head.be   : '0;
  assign misalign_o  = misalign_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    misalign_d = hs && illegal;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  // Storage needs no reset; validity is tracked by count and pointers.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) buf_q[wr_ptr_q] <= wr_entry;
  end

endmodule

// File: tb/tb_store_narrow_buffer.sv
// Directed self-checking bench for store_narrow_buffer (DEPTH=2).
// Inputs change #1 after a rising edge; outputs are checked there too.
module tb_store_narrow_buffer;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  mem_be;
  logic        misalign;
  logic        empty;

  int n_chk;
  int n_err;

  store_narrow_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_size_i  (req_size),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .mem_valid_o (mem_valid),
    .mem_ready_i (mem_ready),
    .mem_addr_o  (mem_addr),
    .mem_data_o  (mem_data),
    .mem_be_o    (mem_be),
    .misalign_o  (misalign),
    .empty_o     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] d);
    req_valid = 1'b1;
    req_size  = sz;
    req_addr  = a;
    req_data  = d;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(mem_valid), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_addr"}, mem_addr, 32'd0);
    chk({tag, "_be"}, 32'(mem_be), 32'd0);
  endtask

  initial begin
    n_chk     = 0;
    n_err     = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_size  = 2'b00;
    req_addr  = '0;
    req_data  = '0;
    mem_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_mis", 32'(misalign), 32'd0);
    chk("rst_data", mem_data, 32'd0);
    chk_idle("rst");

    // sb at lane 3, drained the next cycle
    mem_ready = 1'b1;
    push(2'b00, 32'h0000_1003, 32'hAABB_CCDD);
    chk("sb_valid", 32'(mem_valid), 32'd1);
    chk("sb_addr", mem_addr, 32'h0000_1000);
    chk("sb_data", mem_data, 32'hDDDD_DDDD);
    chk("sb_be", 32'(mem_be), 32'h8);
    tick();
    chk_idle("sb_pop");

    push(2'b01, 32'h0000_2002, 32'h1234_5678);
    chk("sh_data", mem_data, 32'h5678_5678);
    chk("sh_be", 32'(mem_be), 32'hC);
    chk("sh_addr", mem_addr, 32'h0000_2000);
    push(2'b10, 32'h0000_2004, 32'h1234_5678);
    chk("sw_data", mem_data, 32'h1234_5678);
    chk("sw_be", 32'(mem_be), 32'hF);
    chk("sw_addr", mem_addr, 32'h0000_2004);
    tick();
    chk_idle("sw_pop");

    push(2'b00, 32'h0000_2101, 32'h0000_00EE);
    chk("sb1_be", 32'(mem_be), 32'h2);
    chk("sb1_data", mem_data, 32'hEEEE_EEEE);
    push(2'b01, 32'h0000_2100, 32'h0000_BEEF);
    chk("sh0_be", 32'(mem_be), 32'h3);
    tick();

    // misaligned and reserved requests are consumed, never enqueued
    push(2'b10, 32'h0000_3001, 32'h1111_1111);
    chk("mis_sw", 32'(misalign), 32'd1);
    chk_idle("mis_sw");
    tick();
    chk("mis_sw_fall", 32'(misalign), 32'd0);
    push(2'b01, 32'h0000_3005, 32'h2222_2222);
    chk("mis_sh", 32'(misalign), 32'd1);
    chk_idle("mis_sh");
    tick();
    chk("mis_sh_fall", 32'(misalign), 32'd0);
    push(2'b11, 32'h0000_4000, 32'h3333_3333);
    chk("mis_rsvd", 32'(misalign), 32'd1);
    chk_idle("mis_rsvd");
    tick();
    chk("mis_rsvd_fall", 32'(misalign), 32'd0);

    // fill with memory stalled, then drain in order
    mem_ready = 1'b0;
    push(2'b00, 32'h0000_5000, 32'h0000_0011);
    chk("fill1_ready", 32'(req_ready), 32'd1);
    push(2'b00, 32'h0000_5001, 32'h0000_0022);
    chk("full_ready", 32'(req_ready), 32'd0);
    chk("full_data", mem_data, 32'h1111_1111);
    chk("full_be", 32'(mem_be), 32'h1);
    chk("full_addr", mem_addr, 32'h0000_5000);
    // a request while full must not be taken
    push(2'b10, 32'h0000_5008, 32'hDEAD_BEEF);
    chk("stall_ready", 32'(req_ready), 32'd0);
    chk("stall_data", mem_data, 32'h1111_1111);
    chk("stall_be", 32'(mem_be), 32'h1);
    chk("stall_mis", 32'(misalign), 32'd0);
    mem_ready = 1'b1;
    tick();
    chk("drain1_ready", 32'(req_ready), 32'd1);
    chk("drain1_data", mem_data, 32'h2222_2222);
    chk("drain1_be", 32'(mem_be), 32'h2);
    tick();
    chk_idle("drain2");

    // one entry held, then simultaneous push and pop
    mem_ready = 1'b0;
    push(2'b10, 32'h0000_7000, 32'hAAAA_0001);
    mem_ready = 1'b1;
    push(2'b10, 32'h0000_7004, 32'hAAAA_0002);
    chk("pp_valid", 32'(mem_valid), 32'd1);
    chk("pp_ready", 32'(req_ready), 32'd1);
    chk("pp_data", mem_data, 32'hAAAA_0002);
    chk("pp_addr", mem_addr, 32'h0000_7004);
    tick();
    chk_idle("pp_pop");

    // 3*DEPTH back-to-back stores: pointer wrap and ordering
    for (int i = 0; i < 3 * DEPTH; i++) begin
      push(2'b10, 32'h0000_6000 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
      chk("wrap_data", mem_data, 32'hC0DE_0000 + 32'(i));
      chk("wrap_addr", mem_addr, 32'h0000_6000 + 32'(4 * i));
    end
    tick();
    chk_idle("wrap_end");

    // reset with two pending entries and memory ready
    mem_ready = 1'b0;
    push(2'b10, 32'h0000_8000, 32'h0000_0001);
    push(2'b10, 32'h0000_8004, 32'h0000_0002);
    chk("prerst_ready", 32'(req_ready), 32'd0);
    mem_ready = 1'b1;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_ready", 32'(req_ready), 32'd1);
    chk("mrst_mis", 32'(misalign), 32'd0);
    chk("mrst_data", mem_data, 32'd0);
    chk_idle("mrst");
    tick();
    chk_idle("mrst_after");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
